instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the instruction decode stage: accepts field-level instruction requests (format, opcode, funct, register numbers, shamt, immediate, jump index) over a valid/ready stream.
- Packs each request into a 32-bit MIPS word and writes the words sequentially into instruction memory through a stallable write port.
- Used by the boot/program loader and by test benches to fill instruction memory ahead of the CPU being released from reset.

Parameters:
- AW, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, words allowed per program; must be ≤ 2^AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a program load at base_addr.
- base_addr  in  AW  first word address.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_fmt  in  2  00 I-type, 01 J-type, 10 R-type, 11 illegal.
- in_opc  in  6  opcode (ignored for R-type).
- in_fun  in  6  funct (R-type only).
- in_rs, in_rt, in_rd, in_sa  in  5 each  register numbers and shift amount.
- in_imm  in  16  immediate (I-type).
- in_iindex  in  26  jump index (J-type).
- in_last  in  1  marks the final request of the program.
- im_we  out  1  write request to instruction memory.
- im_addr  out  AW  word address.
- im_wdata  out  32  encoded word.
- im_ready  in  1  memory accepts the write when im_we & im_ready.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at program completion.
- count  out  AW+1  words written in the current load.
- err  out  1  sticky error flag, cleared on start.

Behaviour:
- Reset (async, immediate): state IDLE; im_we=0, im_addr=0, im_wdata=0, in_ready=0, busy=0, done=0, count=0, err=0. Any pending write is dropped.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 loads addr←base_addr, count←0, err←0; next state RUN.
- RUN:
  - in_ready = !im_we | im_ready (single-entry output register; full throughput when memory never stalls).
  - On accept, the encoded word is registered next cycle: im_we=1, im_addr=addr, im_wdata=word. Latency from accept to im_we is 1 cycle.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, sa, fun}.
  - I-type: {opc, rs, rt, imm}.
  - J-type: {opc, iindex}.
  - fmt 11: request is consumed, nothing is written, err←1.
- Write handshake:
  - im_we, im_addr and im_wdata hold stable until im_ready.
  - On im_we & im_ready: addr←addr+1, wrapping mod 2^AW; count←count+1.
  - If a new accept occurs in the same cycle, the new word replaces the register and im_we stays 1.
- Accept with in_last=1: RUN→DRAIN. In DRAIN, in_ready=0.
- DRAIN: when no write is pending, go to DONE.
- Illegal last request: an fmt-11 request with in_last=1 goes directly to DRAIN.
- Capacity limit: when count+pending = MAX_WORDS and in_last has not been seen, in_ready=0, err←1, state→DRAIN. The program is truncated.
- DONE: done=1 for exactly one cycle, then IDLE. count holds until the next start.
- start while busy is ignored. in_valid in IDLE is ignored.
- Address wrap past 2^AW−1 to 0 is legal and is not an error.

Optional Feature:
- Macro: INSTR_ENC_CHECK_EN.
- When defined, semantic checks set err (the word is still written):
  - I-type with opc 000000 or 00001x.
  - J-type with opc not 00001x.
  - R-type with nonzero sa on a non-shift funct. Shift functs are 000000, 000010, 000011.
- When undefined, only the fmt=11 and capacity conditions set err; the check logic is absent.

Decomposition:
- Shared package mips_pkg holds:
  - format codes FMT_I=2'b00, FMT_J=2'b01, FMT_R=2'b10, FMT_BAD=2'b11 (the same codes the decoder's type classification uses);
  - opcode constants OPC_SPECIAL, OPC_J, OPC_JAL, OPC_LW, OPC_SW;
  - funct constants FUN_SLL, FUN_SRL, FUN_SRA, FUN_JR, FUN_JALR;
  - state enum.
- One natural combinational sub-module, instr_pack: fields in, 32-bit word plus illegal/check flags out. The FSM, address and count logic stay in instr_encoder.

Test Plan:
- start, base_addr=0x010; R-type rs=1 rt=2 rd=3 sa=0 fun=100001, in_last=1, im_ready=1 → im_wdata=0x00221821 at addr 0x010 one cycle after accept; done pulses; count=1.
- I-type opc=100011 rs=29 rt=8 imm=0xFFFC, then J-type opc=000011 iindex=0x0100000 (in_last=1) → words 0x8FA8FFFC then 0x0C100000 at consecutive addresses.
- im_ready held low 3 cycles during a write → im_we/addr/data stable, in_ready=0 after one buffered word, nothing lost; count correct.
- fmt=11 mid-stream → no write for that request, err=1, following words written at contiguous addresses.
- MAX_WORDS=4, stream 6 requests without in_last → 4 writes, err=1, done pulse, count=4; base_addr=2^AW−1 → second write at addr 0.
- Assert rst during a stalled write → all outputs 0 asynchronously; next start loads cleanly.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, format codes and the encoder state type.
// Used by instr_encoder and instr_pack.
package mips_pkg;

    localparam logic [1:0] FMT_I   = 2'b00;
    localparam logic [1:0] FMT_J   = 2'b01;
    localparam logic [1:0] FMT_R   = 2'b10;
    localparam logic [1:0] FMT_BAD = 2'b11;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FUN_SLL  = 6'b000000;
    localparam logic [5:0] FUN_SRL  = 6'b000010;
    localparam logic [5:0] FUN_SRA  = 6'b000011;
    localparam logic [5:0] FUN_JR   = 6'b001000;
    localparam logic [5:0] FUN_JALR = 6'b001001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    function automatic logic is_jump_opc(input logic [5:0] opc);
        return (opc == OPC_J) || (opc == OPC_JAL);
    endfunction

    function automatic logic is_shift_fun(input logic [5:0] fun);
        return (fun == FUN_SLL) || (fun == FUN_SRL) || (fun == FUN_SRA);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit MIPS word from request fields.
// Optional semantic checks are compiled in with INSTR_ENC_CHECK_EN.
module instr_pack
    import mips_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opc,
    input  logic [5:0]  fun,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] iindex,
    output logic [31:0] word,
    output logic        illegal,
    output logic        check_err
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R:   word = {OPC_SPECIAL, rs, rt, rd, sa, fun};
            FMT_I:   word = {opc, rs, rt, imm};
            FMT_J:   word = {opc, iindex};
            default: illegal = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    // Flags suspicious but encodable requests; the word is still written.
    always_comb begin
        check_err = 1'b0;
        case (fmt)
            FMT_I:   check_err = (opc == OPC_SPECIAL) || is_jump_opc(opc);
            FMT_J:   check_err = !is_jump_opc(opc);
            FMT_R:   check_err = (sa != 5'd0) && !is_shift_fun(fun);
            default: check_err = 1'b0;
        endcase
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams field-level requests into packed MIPS words written to instruction memory.
// Optional semantic checking is enabled by defining INSTR_ENC_CHECK_EN.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int AW        = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_fmt,
    input  logic [5:0]    in_opc,
    input  logic [5:0]    in_fun,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_sa,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_iindex,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    input  logic          im_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err
);

    enc_state_t    state_reg;
    logic [AW-1:0] addr_reg;
    logic          we_reg;
    logic [31:0]   wdata_reg;
    logic [AW:0]   count_reg;
    logic          err_reg;

    logic [31:0]   word;
    logic          illegal;
    logic          check_err;
    logic          wr_done;
    logic          accept;
    logic          cap_full;
    logic [AW+1:0] fill;

    instr_pack u_pack (
        .fmt       (in_fmt),
        .opc       (in_opc),
        .fun       (in_fun),
        .rs        (in_rs),
        .rt        (in_rt),
        .rd        (in_rd),
        .sa        (in_sa),
        .imm       (in_imm),
        .iindex    (in_iindex),
        .word      (word),
        .illegal   (illegal),
        .check_err (check_err)
    );

    // Words committed plus the one sitting in the output register.
    assign fill     = {1'b0, count_reg} + (AW+2)'(we_reg);
    assign cap_full = (state_reg == ST_RUN) && (fill == (AW+2)'(MAX_WORDS));
    assign wr_done  = we_reg & im_ready;
    assign in_ready = (state_reg == ST_RUN) && (!we_reg || im_ready) && !cap_full;
    assign accept   = in_valid & in_ready;

    // addr_reg always names the slot of the pending word, so a word accepted
    // while the previous one retires lands on the incremented address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (wr_done) begin
                addr_reg  <= addr_reg + AW'(1);
                count_reg <= count_reg + (AW+1)'(1);
            end
            if (accept && !illegal) begin
                we_reg    <= 1'b1;
                wdata_reg <= word;
            end else if (wr_done) begin
                we_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg  <= base_addr;
                        count_reg <= '0;
                        err_reg   <= 1'b0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cap_full) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_DRAIN;
                    end else if (accept) begin
                        if (illegal || check_err)
                            err_reg <= 1'b1;
                        if (in_last)
                            state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!we_reg)
                        state_reg <= ST_DONE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign im_we    = we_reg;
    assign im_addr  = addr_reg;
    assign im_wdata = wdata_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign count    = count_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a request-level model.
// The model also honours INSTR_ENC_CHECK_EN when the build defines it.
module tb_instr_encoder;

    localparam int AW   = 6;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_fmt;
    logic [5:0]    in_opc;
    logic [5:0]    in_fun;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [4:0]    in_sa;
    logic [15:0]   in_imm;
    logic [25:0]   in_iindex;
    logic          in_last;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          im_ready;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          err;

    instr_encoder #(.AW(AW), .MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opc    (in_opc),
        .in_fun    (in_fun),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_sa     (in_sa),
        .in_imm    (in_imm),
        .in_iindex (in_iindex),
        .in_last   (in_last),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .im_ready  (im_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  opc;
        logic [5:0]  fun;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [25:0] iindex;
        logic        last;
    } req_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    req_t prog[$];
    wr_t  exp_q[$];
    wr_t  got_q[$];
    int   exp_count;
    bit   exp_err;
    bit   mon_en = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Encoding rules written as bit-field arithmetic on the request.
    function automatic logic [31:0] model_word(input req_t r);
        case (r.fmt)
            2'b10:   return (32'(r.rs) << 21) | (32'(r.rt) << 16) | (32'(r.rd) << 11) | (32'(r.sa) << 6) | 32'(r.fun);
            2'b00:   return (32'(r.opc) << 26) | (32'(r.rs) << 21) | (32'(r.rt) << 16) | 32'(r.imm);
            2'b01:   return (32'(r.opc) << 26) | 32'(r.iindex);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_semantic_bad(input req_t r);
`ifdef INSTR_ENC_CHECK_EN
        bit jmp;
        jmp = (r.opc == 6'd2) || (r.opc == 6'd3);
        case (r.fmt)
            2'b00:   return (r.opc == 6'd0) || jmp;
            2'b01:   return !jmp;
            2'b10:   return (r.sa != 5'd0) && !(r.fun == 6'd0 || r.fun == 6'd2 || r.fun == 6'd3);
            default: return 1'b0;
        endcase
`else
        return (r.fmt == 2'b11) && 1'b0;
`endif
    endfunction

    function automatic req_t mk(input logic [1:0] fmt, input logic [5:0] opc, input logic [5:0] fun,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] sa, input logic [15:0] imm, input logic [25:0] iindex,
                                input logic last);
        req_t r;
        r.fmt = fmt; r.opc = opc; r.fun = fun; r.rs = rs; r.rt = rt; r.rd = rd;
        r.sa = sa; r.imm = imm; r.iindex = iindex; r.last = last;
        return r;
    endfunction

    function automatic req_t rand_req(input bit allow_bad);
        req_t r;
        r.fmt    = (allow_bad && $urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.opc    = 6'($urandom);
        r.fun    = 6'($urandom);
        r.rs     = 5'($urandom);
        r.rt     = 5'($urandom);
        r.rd     = 5'($urandom);
        r.sa     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
        r.imm    = 16'($urandom);
        r.iindex = 26'($urandom);
        r.last   = 1'b0;
        return r;
    endfunction

    // Which requests get consumed, where their words land, and the final flags.
    task automatic build_expect(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        wr_t w;
        exp_q.delete();
        got_q.delete();
        exp_err = 1'b0;
        a = base;
        foreach (prog[i]) begin
            if (prog[i].fmt == 2'b11) begin
                exp_err = 1'b1;
            end else begin
                w.a = a;
                w.d = model_word(prog[i]);
                exp_q.push_back(w);
                a = a + 1'b1;
                if (model_semantic_bad(prog[i])) exp_err = 1'b1;
            end
            if (prog[i].last) break;
            if (exp_q.size() == MAXW) begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_count = exp_q.size();
    endtask

    task automatic drive(input req_t r, input bit v);
        in_valid  = v;
        in_fmt    = r.fmt;
        in_opc    = r.opc;
        in_fun    = r.fun;
        in_rs     = r.rs;
        in_rt     = r.rt;
        in_rd     = r.rd;
        in_sa     = r.sa;
        in_imm    = r.imm;
        in_iindex = r.iindex;
        in_last   = r.last;
    endtask

    task automatic run_program(input logic [AW-1:0] base, input int valid_pct, input int ready_pct,
                               input int stall_at);
        int idx;
        int cyc;
        bit seen_done;
        build_expect(base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 500) begin
            if (idx < prog.size() && $urandom_range(0, 99) < valid_pct)
                drive(prog[idx], 1'b1);
            else
                drive(rand_req(1'b1), 1'b0);
            // Stray starts while busy must be ignored.
            start = ($urandom_range(0, 15) == 0);
            base_addr = AW'($urandom);
            if (cyc >= stall_at && cyc < stall_at + 3)
                im_ready = 1'b0;
            else
                im_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        im_ready = 1'b1;
        check("program_completed", seen_done, 1'b1);
    endtask

    // Per-cycle compare against the model.
    logic          pend_acc;
    logic [31:0]   pend_word;
    logic          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_data;
    logic          prev_done;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            pend_acc   <= 1'b0;
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (pend_acc) begin
                check("accept_latency_we", im_we, 1'b1);
                check("accept_latency_data", im_wdata, pend_word);
            end
            if (prev_stall) begin
                check("stall_we_hold", im_we, 1'b1);
                check("stall_addr_hold", im_addr, prev_addr);
                check("stall_data_hold", im_wdata, prev_data);
            end
            if (im_we && !im_ready)
                check("stall_in_ready", in_ready, 1'b0);
            if (!busy)
                check("idle_in_ready", in_ready, 1'b0);
            if (im_we && im_ready) begin
                wr_t w;
                w.a = im_addr;
                w.d = im_wdata;
                got_q.push_back(w);
                $display("write addr=%0h data=%h", im_addr, im_wdata);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", im_addr, e.a);
                    check("write_data", im_wdata, e.d);
                end
            end
            if (done) begin
                check("done_single_cycle", prev_done, 1'b0);
                check("done_count", count, exp_count);
                check("done_err", err, exp_err);
                check("done_all_written", exp_q.size(), 0);
            end
            pend_acc   <= in_valid && in_ready && (in_fmt != 2'b11);
            pend_word  <= model_word(mk(in_fmt, in_opc, in_fun, in_rs, in_rt, in_rd, in_sa,
                                        in_imm, in_iindex, in_last));
            prev_stall <= im_we && !im_ready;
            prev_addr  <= im_addr;
            prev_data  <= im_wdata;
            prev_done  <= done;
        end
    end

    initial begin
        req_t r;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        im_ready = 1'b1;
        drive(mk(2'b00, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0), 1'b0);
        #12;
        check("reset_im_we", im_we, 1'b0);
        check("reset_im_addr", im_addr, 0);
        check("reset_im_wdata", im_wdata, 0);
        check("reset_busy", busy, 1'b0);
        check("reset_count", count, 0);
        check("reset_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single R-type word at 0x10.
        prog.delete();
        prog.push_back(mk(2'b10, 6'd0, 6'b100001, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1));
        check("model_pin_rtype", model_word(prog[0]), 32'h00221821);
        run_program(6'h10, 100, 100, 1000);
        check("t1_addr", got_q.size() > 0 ? got_q[0].a : 6'h3F, 6'h10);
        check("t1_data", got_q.size() > 0 ? got_q[0].d : 32'h0, 32'h00221821);
        check("t1_count", count, 1);

        // LW followed by JAL at consecutive addresses.
        prog.delete();
        prog.push_back(mk(2'b00, 6'b100011, 6'd0, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'd0, 1'b0));
        prog.push_back(mk(2'b01, 6'b000011, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100000, 1'b1));
        check("model_pin_itype", model_word(prog[0]), 32'h8FA8FFFC);
        check("model_pin_jtype", model_word(prog[1]), 32'h0C100000);
        run_program(6'h05, 100, 100, 1000);
        check("t2_word0", got_q.size() > 1 ? got_q[0].d : 32'h0, 32'h8FA8FFFC);
        check("t2_word1", got_q.size() > 1 ? got_q[1].d : 32'h0, 32'h0C100000);
        check("t2_addr1", got_q.size() > 1 ? got_q[1].a : 6'h0, 6'h06);

        // Memory stall of three cycles right after the first word.
        prog.delete();
        for (int i = 0; i < 3; i++) begin
            r = rand_req(1'b0);
            r.fmt = 2'b00;
            r.opc = 6'b100011;
            r.last = (i == 2);
            prog.push_back(r);
        end
        run_program(6'h20, 100, 100, 1);
        check("t3_count", count, 3);

        // Illegal request mid-stream.
        prog.delete();
        prog.push_back(mk(2'b00, 6'b101011, 6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0010, 26'd0, 1'b0));
        prog.push_back(mk(2'b11, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0));
        prog.push_back(mk(2'b00, 6'b101011, 6'd0, 5'd6, 5'd7, 5'd0, 5'd0, 16'h0020, 26'd0, 1'b1));
        run_program(6'h30, 100, 100, 1000);
        check("t4_err", err, 1'b1);
        check("t4_count", count, 2);
        check("t4_addr1", got_q.size() > 1 ? got_q[1].a : 6'h0, 6'h31);

        // Capacity truncation with wrap from the top address.
        prog.delete();
        for (int i = 0; i < 6; i++) begin
            r = rand_req(1'b0);
            r.fmt = 2'b00;
            r.opc = 6'b100011;
            prog.push_back(r);
        end
        run_program(6'h3F, 100, 100, 1000);
        check("t5_count", count, 4);
        check("t5_err", err, 1'b1);
        check("t5_wrap_addr", got_q.size() > 1 ? got_q[1].a : 6'h3F, 6'h00);

        // Reset during a stalled write.
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 6'h09;
        @(posedge clk); #1;
        start = 1'b0;
        drive(mk(2'b00, 6'b100011, 6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0), 1'b1);
        im_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        check("t6_stalled_we", im_we, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_we", im_we, 1'b0);
        check("t6_rst_addr", im_addr, 0);
        check("t6_rst_data", im_wdata, 0);
        check("t6_rst_in_ready", in_ready, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_count", count, 0);
        check("t6_rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        im_ready = 1'b1;
        mon_en = 1'b1;
        prog.delete();
        prog.push_back(mk(2'b10, 6'd0, 6'b100001, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1));
        run_program(6'h22, 100, 100, 1000);
        check("t6_reload_addr", got_q.size() > 0 ? got_q[0].a : 6'h0, 6'h22);
        check("t6_reload_data", got_q.size() > 0 ? got_q[0].d : 32'h0, 32'h00221821);

        // Randomized programs with random valid and memory back-pressure.
        for (int p = 0; p < 30; p++) begin
            prog.delete();
            if ($urandom_range(0, 3) != 0) begin
                int n;
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    r = rand_req(1'b1);
                    r.last = (i == n - 1);
                    prog.push_back(r);
                end
            end else begin
                for (int i = 0; i < 7; i++) begin
                    r = rand_req(i == 3);
                    prog.push_back(r);
                end
            end
            run_program(AW'($urandom), $urandom_range(40, 100), $urandom_range(30, 100), 1000);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
